// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//   Instruction fetch stage feeding the control unit. Owns the PC, fetches
//   one word at a time from instruction memory over a req/ack handshake,
//   latches it into the instruction register (IR) and offers its split
//   fields to decode/execute with a valid/ready handshake. The control
//   unit's jump decision is applied on the cycle the IR is consumed.
//
//   Optional feature macro: FETCH_HALT_EN
//     defined   : consuming an instruction whose opcode equals HALT_OPC
//                 parks the unit in S_HALT (halted=1) until rst.
//     undefined : HALT_OPC is fetched like any other opcode; halted=0.
//
// Ports
//   clk, rst          clock (rising edge), synchronous active-high reset
//   imem_req   (o)    fetch request valid, held until imem_ack
//   imem_addr  (o)    fetch address, always equal to the PC
//   imem_ack   (i)    imem_rdata is valid this cycle (used in S_REQ only)
//   imem_rdata (i)    instruction word
//   ir_valid   (o)    IR holds an unconsumed instruction
//   ir_ready   (i)    downstream consumes the IR this cycle
//   ir_opcode/ir_ra/ir_rb/ir_imm (o)  IR fields
//   jmp_sel    (i)    jump taken for the current IR
//   jmp_target (i)    jump destination
//   halted     (o)    fetch stopped (FETCH_HALT_EN only)
//
//   Every output is a register or a decode of the state register, so there
//   is no combinational path from ir_ready/jmp_sel/imem_ack to an output.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned PC_W     = 5,
  parameter int unsigned REG_AW   = 2,
  parameter int unsigned IMM_W    = 5,
  parameter logic [3:0]  HALT_OPC = 4'b1111,
  localparam int unsigned INSTR_W = 4 + 2*REG_AW + IMM_W
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [3:0]         ir_opcode,
  output logic [REG_AW-1:0]  ir_ra,
  output logic [REG_AW-1:0]  ir_rb,
  output logic [IMM_W-1:0]   ir_imm,
  input  logic               jmp_sel,
  input  logic [PC_W-1:0]    jmp_target,
  output logic               halted
);

`ifdef FETCH_HALT_EN
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_HALT = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_e;
`endif

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               halt_hit;

  // IR field split: opcode on top, then ra, rb, immediate at the bottom.
  assign ir_opcode = ir_q[INSTR_W-1 -: 4];
  assign ir_ra     = ir_q[INSTR_W-5 -: REG_AW];
  assign ir_rb     = ir_q[INSTR_W-5-REG_AW -: REG_AW];
  assign ir_imm    = ir_q[IMM_W-1:0];

`ifdef FETCH_HALT_EN
  assign halt_hit = (ir_opcode == HALT_OPC);
  assign halted   = (state_q == S_HALT);
`else
  logic unused_halt_opc;
  assign unused_halt_opc = ^HALT_OPC;
  assign halt_hit        = 1'b0;
  assign halted          = 1'b0;
`endif

  assign imem_req  = (state_q == S_REQ);
  assign imem_addr = pc_q;
  assign ir_valid  = (state_q == S_HOLD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    unique case (state_q)
      S_IDLE: state_d = S_REQ;
      S_REQ: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (ir_ready) begin
          // A halt instruction wins over any jump decision on the same cycle.
          if (halt_hit) begin
`ifdef FETCH_HALT_EN
            state_d = S_HALT;
`else
            state_d = S_REQ;
`endif
          end else begin
            state_d = S_REQ;
            if (jmp_sel) pc_d = jmp_target;
          end
        end
      end
`ifdef FETCH_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//   Drives fetch_unit one cycle at a time. A behavioural model tracks what
//   the fetch stage must be doing (idle after reset, request outstanding at
//   the PC, instruction held, or halted) together with the expected PC and
//   IR, and every output is compared after each clock edge. Directed
//   sequences cover the named corner cases, then a long randomized run
//   with random acks, back-pressure, jumps and resets follows.
// ---------------------------------------------------------------------------
module tb_fetch_unit;
  localparam int PC_W    = 5;
  localparam int REG_AW  = 2;
  localparam int IMM_W   = 5;
  localparam int INSTR_W = 4 + 2*REG_AW + IMM_W;
  localparam int DEPTH   = 1 << PC_W;
`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rst;
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               ir_valid;
  logic               ir_ready;
  logic [3:0]         ir_opcode;
  logic [REG_AW-1:0]  ir_ra;
  logic [REG_AW-1:0]  ir_rb;
  logic [IMM_W-1:0]   ir_imm;
  logic               jmp_sel;
  logic [PC_W-1:0]    jmp_target;
  logic               halted;

  always #5 clk = ~clk;

  fetch_unit #(.PC_W(PC_W), .REG_AW(REG_AW), .IMM_W(IMM_W), .HALT_OPC(4'b1111)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .ir_valid(ir_valid), .ir_ready(ir_ready),
    .ir_opcode(ir_opcode), .ir_ra(ir_ra), .ir_rb(ir_rb), .ir_imm(ir_imm),
    .jmp_sel(jmp_sel), .jmp_target(jmp_target), .halted(halted)
  );

  logic [INSTR_W-1:0] mem [DEPTH];
  int total = 0;
  int bad   = 0;

  // Reference model: what the fetch stage is doing and what it must show.
  typedef enum {M_STARTUP, M_FETCHING, M_HOLDING, M_STOPPED} activity_e;
  activity_e          act;
  int                 pc_model;
  logic [INSTR_W-1:0] ir_model;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the fetch rules, check outputs.
  task automatic step(input bit r, input bit a, input bit rd, input bit js, input logic [PC_W-1:0] jt);
    rst        = r;
    imem_ack   = a;
    ir_ready   = rd;
    jmp_sel    = js;
    jmp_target = jt;
    imem_rdata = imem_req ? mem[imem_addr] : INSTR_W'($urandom);
    @(posedge clk);
    if (r) begin
      act      = M_STARTUP;
      pc_model = 0;
      ir_model = '0;
    end else begin
      case (act)
        M_STARTUP: act = M_FETCHING;
        M_FETCHING: if (a) begin
          ir_model = mem[pc_model];
          pc_model = (pc_model + 1) % DEPTH;
          act      = M_HOLDING;
        end
        M_HOLDING: if (rd) begin
          if (HALT_EN && ir_model[INSTR_W-1 -: 4] == 4'hF) act = M_STOPPED;
          else begin
            act = M_FETCHING;
            if (js) pc_model = int'(jt);
          end
        end
        default: ;
      endcase
    end
    #1;
    check_val("imem_req",  32'(imem_req),  32'(act == M_FETCHING));
    check_val("ir_valid",  32'(ir_valid),  32'(act == M_HOLDING));
    check_val("halted",    32'(halted),    32'(act == M_STOPPED));
    check_val("imem_addr", 32'(imem_addr), 32'(pc_model));
    check_val("ir_opcode", 32'(ir_opcode), 32'(ir_model >> (INSTR_W - 4)));
    check_val("ir_ra",     32'(ir_ra),     32'((ir_model >> (IMM_W + REG_AW)) & ((1 << REG_AW) - 1)));
    check_val("ir_rb",     32'(ir_rb),     32'((ir_model >> IMM_W) & ((1 << REG_AW) - 1)));
    check_val("ir_imm",    32'(ir_imm),    32'(ir_model & ((1 << IMM_W) - 1)));
  endtask

  // Free-run with ack=1/ready=1 until the model reaches the wanted activity at pc.
  task automatic run_to(input bit want_hold, input int pc, input string tag);
    int n = 0;
    while (!((want_hold ? act == M_HOLDING : act == M_FETCHING) && pc_model == pc) && n < 200) begin
      step(1'b0, 1'b1, 1'b1, 1'b0, '0);
      n++;
    end
    check_val(tag, 32'(n < 200), 32'd1);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; ir_ready = 1'b0; jmp_sel = 1'b0;
    jmp_target = '0; imem_rdata = '0;
    act = M_STARTUP; pc_model = 0; ir_model = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'(i);

    // Reset for two cycles with ack asserted, then stream with ack=1/ready=1.
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Ack delayed three cycles at address 4.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_to(1'b0, 4, "reach_req4");
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);
    step(1'b0, 1'b1, 1'b0, 1'b0, '0);

    // IR held for five cycles; jumps offered while not consumed are ignored.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b0, 1'b1, 5'd17);
    step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Jump taken when consuming the instruction fetched from pc=3.
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_to(1'b1, 4, "reach_hold3");
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd20);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Jump to 31, consume it, PC wraps to 0.
    run_to(1'b1, (pc_model + 1) % DEPTH, "reach_hold_any");
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd31);
    run_to(1'b1, 0, "reach_hold31");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Reset while a request is outstanding and acked in the same cycle.
    run_to(1'b0, pc_model, "reach_req_any");
    step(1'b1, 1'b1, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, '0);

    // Halt opcode at pc=6.
    mem[6] = {4'hF, 4'h0, 5'd6};
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    run_to(1'b1, 7, "reach_hold6");
    step(1'b0, 1'b0, 1'b1, 1'b1, 5'd25);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic over a random memory image.
    for (int i = 0; i < DEPTH; i++) mem[i] = INSTR_W'($urandom);
    step(1'b1, 1'b0, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0) ? 5'd31 : PC_W'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
